// File: rtl/seq_control_unit.sv
// seq_control_unit -- four-step sequencer for a register/ALU datapath.
//
// Each accepted instruction runs IDLE -> SRC -> CALC -> WB -> IDLE. Every
// step is taken only on a clock edge with run=1. All outputs are registered.
//   IDLE : latch instruction, drive Rx onto the bus, pulse en_s
//   SRC  : drive Ry (or the immediate) onto the bus, set sel, pulse en_c
//   CALC : write back into register Rx (one-hot en_reg), pulse done
//   WB   : clear en_reg/done, return to IDLE
// Formats: fmt=00 reg/reg, fmt=01 immediate, fmt=1x NOP. A NOP keeps the
// same four-step timing and still pulses done, but never raises en_s,
// en_c or en_reg.
//
// Build option: define SEQ_CU_IMM_EN to compile in immediate support.
// Without it, fmt=01 is a NOP, the mux_sel MSB is always 0 and imm is 0.
//
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   run              advance enable; the sequencer holds while low
//   instruction      {Rx, Ry, imm, alu_sel, fmt}
//   mux_sel          bus source (MSB=1 selects the immediate)
//   sel              ALU operation
//   en_s, en_c       source-latch / result-latch load
//   en_reg           one-hot register write enable
//   done             completion pulse
//   busy             high whenever not in IDLE
//   imm              immediate field of the latched instruction
module seq_control_unit #(
  parameter int NREG = 8,
  parameter int RW   = $clog2(NREG),
  parameter int SELW = 3,
  parameter int IW   = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       run,
  input  logic [IW-1:0]              instruction,
  output logic [RW:0]                mux_sel,
  output logic [SELW-1:0]            sel,
  output logic                       en_s,
  output logic                       en_c,
  output logic [NREG-1:0]            en_reg,
  output logic                       done,
  output logic                       busy,
  output logic [IW-2*RW-SELW-5:0]    imm
);

  localparam int IMMW = IW - 2*RW - SELW - 4;

`ifdef SEQ_CU_IMM_EN
  localparam bit IMM_EN = 1'b1;
`else
  localparam bit IMM_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SRC  = 3'd1,
    S_CALC = 3'd2,
    S_WB   = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t            state_q,   state_d;
  logic [IW-1:0]     instr_q,   instr_d;
  logic [RW:0]       mux_sel_q, mux_sel_d;
  logic [SELW-1:0]   sel_q,     sel_d;
  logic              en_s_q,    en_s_d;
  logic              en_c_q,    en_c_d;
  logic [NREG-1:0]   en_reg_q,  en_reg_d;
  logic              done_q,    done_d;
  logic              busy_q,    busy_d;

  // Fields of the incoming instruction (used only at acceptance).
  logic [RW-1:0]     rx_in;
  logic [1:0]        fmt_in;
  // Fields of the latched copy (used by every later step).
  logic [RW-1:0]     rx_q;
  logic [RW-1:0]     ry_q;
  logic [SELW-1:0]   alu_q;
  logic [1:0]        fmt_q;

  assign rx_in  = instruction[IW-1 -: RW];
  assign fmt_in = instruction[1:0];
  assign rx_q   = instr_q[IW-1 -: RW];
  assign ry_q   = instr_q[IW-1-RW -: RW];
  assign alu_q  = instr_q[SELW+1:2];
  assign fmt_q  = instr_q[1:0];

  function automatic logic is_nop(input logic [1:0] fmt);
    return fmt[1] | ((fmt == 2'b01) & ~IMM_EN);
  endfunction

  always_comb begin
    state_d   = state_q;
    instr_d   = instr_q;
    mux_sel_d = mux_sel_q;
    sel_d     = sel_q;
    en_s_d    = en_s_q;
    en_c_d    = en_c_q;
    en_reg_d  = en_reg_q;
    done_d    = done_q;
    busy_d    = busy_q;
    case (state_q)
      S_IDLE: if (run) begin
        instr_d   = instruction;
        mux_sel_d = {1'b0, rx_in};
        en_s_d    = ~is_nop(fmt_in);
        busy_d    = 1'b1;
        state_d   = S_SRC;
      end
      S_SRC: if (run) begin
        en_s_d = 1'b0;
        sel_d  = alu_q;
        if (!is_nop(fmt_q)) begin
          en_c_d = 1'b1;
`ifdef SEQ_CU_IMM_EN
          if (fmt_q == 2'b01) mux_sel_d = {1'b1, {RW{1'b0}}};
          else                mux_sel_d = {1'b0, ry_q};
`else
          mux_sel_d = {1'b0, ry_q};
`endif
        end
        state_d = S_CALC;
      end
      S_CALC: if (run) begin
        en_c_d   = 1'b0;
        en_reg_d = '0;
        if (!is_nop(fmt_q)) en_reg_d[rx_q] = 1'b1;
        done_d   = 1'b1;
        state_d  = S_WB;
      end
      S_WB: if (run) begin
        en_reg_d = '0;
        done_d   = 1'b0;
        busy_d   = 1'b0;
        state_d  = S_IDLE;
      end
      // S_DONE is never entered; it and any illegal encoding recover to
      // IDLE on the next edge without waiting for run.
      default: begin
        state_d   = S_IDLE;
        instr_d   = '0;
        mux_sel_d = '0;
        sel_d     = '0;
        en_s_d    = 1'b0;
        en_c_d    = 1'b0;
        en_reg_d  = '0;
        done_d    = 1'b0;
        busy_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      instr_q   <= '0;
      mux_sel_q <= '0;
      sel_q     <= '0;
      en_s_q    <= 1'b0;
      en_c_q    <= 1'b0;
      en_reg_q  <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      instr_q   <= instr_d;
      mux_sel_q <= mux_sel_d;
      sel_q     <= sel_d;
      en_s_q    <= en_s_d;
      en_c_q    <= en_c_d;
      en_reg_q  <= en_reg_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  assign mux_sel = mux_sel_q;
  assign sel     = sel_q;
  assign en_s    = en_s_q;
  assign en_c    = en_c_q;
  assign en_reg  = en_reg_q;
  assign done    = done_q;
  assign busy    = busy_q;

  // The immediate is the low IMMW bits of the field between Ry and alu_sel.
`ifdef SEQ_CU_IMM_EN
  assign imm = instr_q[SELW+2 +: IMMW];
`else
  assign imm = '0;
`endif

  logic unused_imm_field;
  assign unused_imm_field = ^instr_q[IW-2*RW-1:SELW+2];

endmodule

// File: tb/tb_seq_control_unit.sv
// Directed bench for seq_control_unit: a default-parameter instance and a
// NREG=16/SELW=4/IW=20 instance sharing clk/reset/run. Both step through
// the same state sequence since their state timing does not depend on the
// instruction contents.
module tb_seq_control_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        run;
  logic [15:0] instruction;
  logic [3:0]  mux_sel;
  logic [2:0]  sel;
  logic        en_s, en_c, done, busy;
  logic [7:0]  en_reg;
  logic [2:0]  imm;

  logic [19:0] instr16;
  logic [4:0]  mux_sel16;
  logic [3:0]  sel16;
  logic        en_s16, en_c16, done16, busy16;
  logic [15:0] en_reg16;
  logic [3:0]  imm16;

  int checks = 0;
  int errors = 0;

`ifdef SEQ_CU_IMM_EN
  localparam bit IMM = 1'b1;
`else
  localparam bit IMM = 1'b0;
`endif

  always #5 clk = ~clk;

  seq_control_unit dut (
    .clk(clk), .reset(reset), .run(run), .instruction(instruction),
    .mux_sel(mux_sel), .sel(sel), .en_s(en_s), .en_c(en_c),
    .en_reg(en_reg), .done(done), .busy(busy), .imm(imm)
  );

  seq_control_unit #(.NREG(16), .SELW(4), .IW(20)) dut16 (
    .clk(clk), .reset(reset), .run(run), .instruction(instr16),
    .mux_sel(mux_sel16), .sel(sel16), .en_s(en_s16), .en_c(en_c16),
    .en_reg(en_reg16), .done(done16), .busy(busy16), .imm(imm16)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Checks every output of the default instance.
  task automatic expect_o(input string tag, input logic [31:0] ms, input logic [31:0] sl,
                          input logic es, input logic ec, input logic [31:0] er,
                          input logic d, input logic b);
    chk({tag, ".mux_sel"}, {28'd0, mux_sel}, ms);
    chk({tag, ".sel"},     {29'd0, sel}, sl);
    chk({tag, ".en_s"},    {31'd0, en_s}, {31'd0, es});
    chk({tag, ".en_c"},    {31'd0, en_c}, {31'd0, ec});
    chk({tag, ".en_reg"},  {24'd0, en_reg}, er);
    chk({tag, ".done"},    {31'd0, done}, {31'd0, d});
    chk({tag, ".busy"},    {31'd0, busy}, {31'd0, b});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; run = 1'b0; instruction = '0; instr16 = '0;
    tick(); tick();
    // Reset state
    expect_o("reset", 0, 0, 0, 0, 0, 0, 0);
    chk("reset.imm", {29'd0, imm}, 0);
    chk("reset16.en_reg", {16'd0, en_reg16}, 0);
    chk("reset16.busy", {31'd0, busy16}, 0);

    // Basic reg/reg: 16'h2408 -> Rx=1, Ry=1, alu=2, fmt=00
    reset = 1'b0; run = 1'b1; instruction = 16'h2408;
    tick(); expect_o("basic.e1", 1, 0, 1, 0, 8'h00, 0, 1);
    tick(); expect_o("basic.e2", 1, 2, 0, 1, 8'h00, 0, 1);
    tick(); expect_o("basic.e3", 1, 2, 0, 0, 8'h02, 1, 1);
    tick(); expect_o("basic.e4", 1, 2, 0, 0, 8'h00, 0, 0);
    run = 1'b0;
    tick(); expect_o("basic.idle", 1, 2, 0, 0, 8'h00, 0, 0);

    // Immediate format: 16'h62A5 -> Rx=3, Ry=0, imm field 10101, alu=1, fmt=01
    run = 1'b1; instruction = 16'h62A5;
    tick(); expect_o("imm.e1", 3, 2, IMM, 0, 8'h00, 0, 1);
    tick(); expect_o("imm.e2", IMM ? 8 : 3, 1, 0, IMM, 8'h00, 0, 1);
    chk("imm.value", {29'd0, imm}, IMM ? 5 : 0);
    tick(); expect_o("imm.e3", IMM ? 8 : 3, 1, 0, 0, IMM ? 8'h08 : 8'h00, 1, 1);
    tick(); expect_o("imm.e4", IMM ? 8 : 3, 1, 0, 0, 8'h00, 0, 0);

    // NOP (fmt=10): done still pulses, no enables
    instruction = 16'h2406;
    tick(); expect_o("nop.e1", 1, 1, 0, 0, 8'h00, 0, 1);
    tick(); expect_o("nop.e2", 1, 1, 0, 0, 8'h00, 0, 1);
    tick(); expect_o("nop.e3", 1, 1, 0, 0, 8'h00, 1, 1);
    tick(); expect_o("nop.e4", 1, 1, 0, 0, 8'h00, 0, 0);

    // run held low for 5 cycles in SRC: outputs hold, no extra pulses
    instruction = 16'h2408;
    tick(); expect_o("stall.e1", 1, 1, 1, 0, 8'h00, 0, 1);
    run = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(); expect_o("stall.hold", 1, 1, 1, 0, 8'h00, 0, 1);
    end
    run = 1'b1;
    tick(); expect_o("stall.e2", 1, 2, 0, 1, 8'h00, 0, 1);
    tick(); expect_o("stall.e3", 1, 2, 0, 0, 8'h02, 1, 1);
    tick(); expect_o("stall.e4", 1, 2, 0, 0, 8'h00, 0, 0);

    // Reset in CALC aborts, then 16'hA80C (Rx=5, Ry=2, alu=3) runs normally
    tick(); expect_o("abort.e1", 1, 2, 1, 0, 8'h00, 0, 1);
    tick(); expect_o("abort.e2", 1, 2, 0, 1, 8'h00, 0, 1);
    reset = 1'b1;
    tick(); expect_o("abort.rst", 0, 0, 0, 0, 8'h00, 0, 0);
    reset = 1'b0; instruction = 16'hA80C;
    tick(); expect_o("after.e1", 5, 0, 1, 0, 8'h00, 0, 1);
    tick(); expect_o("after.e2", 2, 3, 0, 1, 8'h00, 0, 1);
    tick(); expect_o("after.e3", 2, 3, 0, 0, 8'h20, 1, 1);
    tick(); expect_o("after.e4", 2, 3, 0, 0, 8'h00, 0, 0);

    // Instruction changes to Rx=5 during SRC: write still targets Rx=1
    instruction = 16'h2408;
    tick(); expect_o("chg.e1", 1, 3, 1, 0, 8'h00, 0, 1);
    instruction = 16'hA80C;
    tick(); expect_o("chg.e2", 1, 2, 0, 1, 8'h00, 0, 1);
    tick(); expect_o("chg.e3", 1, 2, 0, 0, 8'h02, 1, 1);
    tick(); expect_o("chg.e4", 1, 2, 0, 0, 8'h00, 0, 0);

    // Wide instance: Rx=15, Ry=0, alu=0, fmt=00
    instruction = 16'h0000; instr16 = 20'hF0000;
    tick();
    chk("w16.e1.mux_sel", {27'd0, mux_sel16}, 5'h0F);
    chk("w16.e1.en_s", {31'd0, en_s16}, 1);
    chk("w16.e1.busy", {31'd0, busy16}, 1);
    tick();
    chk("w16.e2.en_c", {31'd0, en_c16}, 1);
    chk("w16.e2.mux_sel", {27'd0, mux_sel16}, 5'h00);
    chk("w16.e2.done", {31'd0, done16}, 0);
    chk("w16.e2.en_reg", {16'd0, en_reg16}, 0);
    tick();
    chk("w16.e3.en_reg", {16'd0, en_reg16}, 32'h8000);
    chk("w16.e3.done", {31'd0, done16}, 1);
    chk("w16.e3.en_c", {31'd0, en_c16}, 0);
    tick();
    chk("w16.e4.en_reg", {16'd0, en_reg16}, 0);
    chk("w16.e4.done", {31'd0, done16}, 0);
    chk("w16.e4.busy", {31'd0, busy16}, 0);
    run = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_control_unit.md
SEQ_CONTROL_UNIT -- requirements
Module: seq_control_unit

Interface
REQ-001 The block SHALL have parameter NREG, default 8, meaning number of general registers (power of two, 2..16).
REQ-002 The block SHALL have parameter RW, default $clog2(NREG), meaning register-index width.
REQ-003 The block SHALL have parameter SELW, default 3, meaning ALU-select width.
REQ-004 The block SHALL have parameter IW, default 16, meaning instruction width; IW SHALL be >= 2*RW+SELW+4.
REQ-005 The block SHALL have port clk, input, 1 bit: clock.
REQ-006 The block SHALL have port reset, input, 1 bit: reset, synchronous, active-high.
REQ-007 The block SHALL have port run, input, 1 bit: advance enable; the FSM holds state while low.
REQ-008 The block SHALL have port instruction, input, IW bits: Rx=[IW-1 -: RW], Ry=[IW-1-RW -: RW], alu_sel=[SELW+1:2], fmt=[1:0].
REQ-009 The block SHALL have port mux_sel, output, RW+1 bits: bus source; MSB=1 selects immediate.
REQ-010 The block SHALL have port sel, output, SELW bits: ALU operation.
REQ-011 The block SHALL have port en_s, output, 1 bit: source-latch load.
REQ-012 The block SHALL have port en_c, output, 1 bit: result-latch load.
REQ-013 The block SHALL have port en_reg, output, NREG bits: one-hot register write enable.
REQ-014 The block SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-015 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-016 The block SHALL have port imm, output, IW-2*RW-SELW-4 bits: immediate field instruction[IW-2*RW-1:SELW+2].

Function
REQ-017 States SHALL be IDLE, SRC, CALC, WB, DONE; transitions SHALL occur only on clk edges with run=1.
REQ-018 In IDLE with run=1, the block SHALL latch instruction into an internal register, drive mux_sel={0,Rx}, pulse en_s, and go to SRC; later states SHALL use only the latched copy.
REQ-019 In SRC, the block SHALL drop en_s, drive sel=alu_sel, drive mux_sel={0,Ry} when fmt=00 or {1,0} when fmt=01, pulse en_c, and go to CALC.
REQ-020 In CALC, the block SHALL drop en_c, assert en_reg[Rx] only, assert done, and go to WB.
REQ-021 In WB, the block SHALL clear en_reg and done and go to IDLE.
REQ-022 fmt=10 or 11 SHALL be a NOP: en_c, en_reg, and en_s SHALL be suppressed, done SHALL still pulse at the CALC step, and the fixed 4-step latency SHALL be kept.
REQ-023 If run is low in any state, all outputs SHALL hold their values and en_s/en_c/en_reg/done SHALL NOT re-pulse.
REQ-024 The latency from the accepting edge to done=1 SHALL be 3 run-qualified edges.
REQ-025 At most one bit of en_reg SHALL be set at any time.
REQ-026 A change to instruction while busy=1 SHALL have no effect.
REQ-027 An out-of-range state SHALL return to IDLE on the next edge regardless of run.

Reset
REQ-028 On reset=1, the state SHALL become IDLE and mux_sel, sel, en_s, en_c, en_reg, done, busy, and the latched instruction SHALL become 0, taking priority over run in any state.
REQ-029 Reset asserted mid-operation SHALL abort the instruction with no en_reg pulse on the following edge.

Configuration
REQ-030 Macro SEQ_CU_IMM_EN SHALL compile in immediate support.
REQ-031 With SEQ_CU_IMM_EN defined, fmt=01 SHALL behave per REQ-019 and imm SHALL be driven.
REQ-032 Without SEQ_CU_IMM_EN, fmt=01 SHALL be treated as NOP (REQ-022), the mux_sel MSB SHALL be tied to 0, and imm SHALL be tied to 0.

Verification
REQ-033 The bench SHALL cover: defaults, run held high, instruction 16'h2408 (Rx=1, Ry=1, alu=2, fmt=00) -> en_s at edge 1 with mux_sel=1; en_c at edge 2 with mux_sel=1, sel=2; en_reg=8'h02 and done=1 at edge 3; all cleared at edge 4.
REQ-034 The bench SHALL cover: with SEQ_CU_IMM_EN, fmt=01, Rx=3 -> mux_sel=4'b1000 at SRC, en_reg=8'h08 at CALC; without the macro -> en_reg stays 0 and done still pulses.
REQ-035 The bench SHALL cover: run deasserted for 5 cycles in SRC -> en_c single pulse, done appearing 5 cycles later, no duplicate pulses.
REQ-036 The bench SHALL cover: reset asserted in CALC -> next edge en_reg=0, done=0, busy=0, and the next instruction executes normally.
REQ-037 The bench SHALL cover: NREG=16, SELW=4, IW=20, Rx=15 -> en_reg=16'h8000 one-hot, latency 3.
REQ-038 The bench SHALL cover: instruction changed to Rx=5 during SRC -> write still goes to the originally latched Rx.
